// File: rtl/ram_bist_pkg.sv
// Shared definitions for the 4x4 RAM March C- self-test: FSM states,
// the march element table and small word helpers.
package ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_t;

    // One march element: address direction, up to two ops, and the data
    // polarity of each op (0 = background word, 1 = its complement).
    typedef struct packed {
        logic desc;
        op_t  op1;
        logic pol1;
        op_t  op2;
        logic pol2;
    } march_elem_t;

    localparam int NUM_ELEM = 6;
    localparam int NUM_BG   = 2;

    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    localparam march_elem_t ELEM_0 = '{desc: 1'b0, op1: OP_WR, pol1: 1'b0, op2: OP_NONE, pol2: 1'b0};
    localparam march_elem_t ELEM_1 = '{desc: 1'b0, op1: OP_RD, pol1: 1'b0, op2: OP_WR,   pol2: 1'b1};
    localparam march_elem_t ELEM_2 = '{desc: 1'b0, op1: OP_RD, pol1: 1'b1, op2: OP_WR,   pol2: 1'b0};
    localparam march_elem_t ELEM_3 = '{desc: 1'b1, op1: OP_RD, pol1: 1'b0, op2: OP_WR,   pol2: 1'b1};
    localparam march_elem_t ELEM_4 = '{desc: 1'b1, op1: OP_RD, pol1: 1'b1, op2: OP_WR,   pol2: 1'b0};
    localparam march_elem_t ELEM_5 = '{desc: 1'b1, op1: OP_RD, pol1: 1'b0, op2: OP_NONE, pol2: 1'b0};
    localparam march_elem_t ELEM_NIL = '{desc: 1'b0, op1: OP_NONE, pol1: 1'b0, op2: OP_NONE, pol2: 1'b0};

    function automatic march_elem_t march_elem(input logic [2:0] idx);
        case (idx)
            3'd0:    return ELEM_0;
            3'd1:    return ELEM_1;
            3'd2:    return ELEM_2;
            3'd3:    return ELEM_3;
            3'd4:    return ELEM_4;
            3'd5:    return ELEM_5;
            default: return ELEM_NIL;
        endcase
    endfunction

    function automatic op_t elem_op(input march_elem_t el, input logic op_idx);
        return op_idx ? el.op2 : el.op1;
    endfunction

    function automatic logic elem_pol(input march_elem_t el, input logic op_idx);
        return op_idx ? el.pol2 : el.pol1;
    endfunction

    function automatic logic [3:0] bg_word(input logic [3:0] bg, input logic pol);
        return pol ? ~bg : bg;
    endfunction

endpackage

// File: rtl/bist_addr_seq.sv
// Two-bit up/down address counter for the march walk. Loads to 0 or 3
// at the start of an element and flags the final address of the walk.
module bist_addr_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       load_hi,
    input  logic       step,
    input  logic       down,
    output logic [1:0] addr,
    output logic       last
);

    // Address register: load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= 2'd0;
        end else if (load) begin
            addr <= load_hi ? 2'd3 : 2'd0;
        end else if (step) begin
            addr <= down ? addr - 2'd1 : addr + 2'd1;
        end
    end

    assign last = down ? (addr == 2'd0) : (addr == 2'd3);

endmodule

// File: rtl/ram_4x4_bist.sv
// March C- self-test initiator for the 4-word x 4-bit RAM. Walks the six
// march elements over two data backgrounds, stops on the first miscompare
// and reports the failing address, expected and received words.
module ram_4x4_bist
    import ram_bist_pkg::*;
#(
    parameter logic [3:0]  BG_A      = 4'h0,
    parameter logic [3:0]  BG_B      = 4'h5,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_addr,
    output logic [3:0] fail_exp,
    output logic [3:0] fail_got,
    output logic [3:0] ram_data_in,
    output logic [1:0] ram_ad,
    output logic       ram_en,
    output logic       ram_rdwr,
    input  logic [3:0] ram_data_out
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_WAIT);
    localparam logic       BG_LAST   = 1'(NUM_BG - 1);

    state_t      state;
    logic        bg_idx;
    logic [2:0]  elem_idx;
    logic        op_idx;
    logic [1:0]  wait_cnt;

    march_elem_t cur_el;
    march_elem_t nxt_el;
    logic        cur_rd;
    logic [3:0]  cur_word;
    logic        op_end;
    logic        miscmp;

    logic        nxt_bg;
    logic [2:0]  nxt_elem;
    logic        nxt_op;
    logic        nxt_rd;
    logic [3:0]  nxt_word;
    logic        run_end;

    logic        seq_load;
    logic        seq_load_hi;
    logic        seq_step;
    logic        seq_down;
    logic        seq_last;

    bist_addr_seq u_addr_seq (
        .clk     (clk),
        .rst     (rst),
        .load    (seq_load),
        .load_hi (seq_load_hi),
        .step    (seq_step),
        .down    (seq_down),
        .addr    (ram_ad),
        .last    (seq_last)
    );

    // Decode the op currently on the RAM pins and decide whether it ends
    // this cycle; reads are only compared in their final held cycle.
    always_comb begin
        cur_el   = march_elem(elem_idx);
        cur_rd   = (elem_op(cur_el, op_idx) == OP_RD);
        cur_word = bg_word(bg_idx ? BG_B : BG_A, elem_pol(cur_el, op_idx));
        op_end   = !cur_rd || (wait_cnt == WAIT_LAST);
        miscmp   = (state == ST_RUN) && cur_rd && op_end && (ram_data_out != cur_word);
    end

    // Work out the position of the next op and steer the address counter.
    always_comb begin
        nxt_bg      = bg_idx;
        nxt_elem    = elem_idx;
        nxt_op      = 1'b0;
        run_end     = 1'b0;
        seq_load    = 1'b0;
        seq_load_hi = 1'b0;
        seq_step    = 1'b0;
        seq_down    = cur_el.desc;
        if (state != ST_RUN) begin
            seq_load = start;
        end else if (miscmp) begin
            seq_load = 1'b1;
        end else if (op_end) begin
            if (!op_idx && (cur_el.op2 != OP_NONE)) begin
                nxt_op = 1'b1;
            end else if (!seq_last) begin
                seq_step = 1'b1;
            end else begin
                seq_load = 1'b1;
                if (elem_idx == LAST_ELEM) begin
                    nxt_elem = 3'd0;
                    if (bg_idx == BG_LAST) begin
                        run_end = 1'b1;
                    end else begin
                        nxt_bg = bg_idx + 1'b1;
                    end
                end else begin
                    nxt_elem = elem_idx + 3'd1;
                end
            end
        end
        nxt_el      = march_elem(nxt_elem);
        seq_load_hi = seq_load && (state == ST_RUN) && !miscmp && nxt_el.desc;
        nxt_rd      = (elem_op(nxt_el, nxt_op) == OP_RD);
        nxt_word    = bg_word(nxt_bg ? BG_B : BG_A, elem_pol(nxt_el, nxt_op));
    end

    // Control FSM with registered status and RAM-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= 2'd0;
            fail_exp    <= 4'h0;
            fail_got    <= 4'h0;
            ram_en      <= 1'b0;
            ram_rdwr    <= 1'b1;
            ram_data_in <= 4'h0;
            bg_idx      <= 1'b0;
            elem_idx    <= 3'd0;
            op_idx      <= 1'b0;
            wait_cnt    <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_addr   <= 2'd0;
                        fail_exp    <= 4'h0;
                        fail_got    <= 4'h0;
                        bg_idx      <= 1'b0;
                        elem_idx    <= 3'd0;
                        op_idx      <= 1'b0;
                        wait_cnt    <= 2'd0;
                        ram_en      <= 1'b1;
                        ram_rdwr    <= (ELEM_0.op1 == OP_RD);
                        ram_data_in <= bg_word(BG_A, ELEM_0.pol1);
                    end
                end
                ST_RUN: begin
                    if (miscmp) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        fail_addr   <= ram_ad;
                        fail_exp    <= cur_word;
                        fail_got    <= ram_data_out;
                        ram_en      <= 1'b0;
                        ram_rdwr    <= 1'b1;
                        ram_data_in <= 4'h0;
                    end else if (!op_end) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else if (run_end) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b1;
                        ram_en      <= 1'b0;
                        ram_rdwr    <= 1'b1;
                        ram_data_in <= 4'h0;
                        wait_cnt    <= 2'd0;
                    end else begin
                        bg_idx      <= nxt_bg;
                        elem_idx    <= nxt_elem;
                        op_idx      <= nxt_op;
                        wait_cnt    <= 2'd0;
                        ram_rdwr    <= nxt_rd;
                        ram_data_in <= nxt_rd ? 4'h0 : nxt_word;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_4x4_bist.md
Name: ram_4x4_bist

Overview:
- Built-in self-test initiator for the 4-word x 4-bit RAM block; drives the RAM's data_in/ad_in/en/rdwr pins and checks data_out.
- Runs a word-oriented March C- test over two data backgrounds and stops on the first mismatch.
- Reports pass/fail plus the failing address, expected word and received word.
- Sits beside the RAM at the same hierarchy level; once done, its RAM-side outputs go idle so normal logic can use the RAM.

Parameters:
- BG_A, 4'h0, first data background (the "0" word; the "1" word is ~BG_A).
- BG_B, 4'h5, second data background (the "0" word; the "1" word is ~BG_B).
- READ_WAIT, 1, extra cycles a read is held before data_out is compared (range 0..3).

Ports:
- clk, input, 1, single clock; everything updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; accepted only in IDLE or DONE.
- busy, output, 1, high while a test is running.
- done, output, 1, high from the end of a test until the next accepted start.
- pass, output, 1, valid while done=1; 1 means no mismatch was found.
- fail_addr, output, 2, address of the first mismatch.
- fail_exp, output, 4, expected word at the first mismatch.
- fail_got, output, 4, word actually read at the first mismatch.
- ram_data_in, output, 4, write data driven to the RAM.
- ram_ad, output, 2, address driven to the RAM.
- ram_en, output, 1, RAM decoder enable.
- ram_rdwr, output, 1, RAM direction: 1 = read, 0 = write.
- ram_data_out, input, 4, RAM read data.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - busy=0, done=0, pass=0.
  - fail_addr=0, fail_exp=0, fail_got=0.
  - ram_en=0, ram_rdwr=1, ram_ad=0, ram_data_in=0.
  - State = IDLE.
- Reset mid-test: the FSM returns to IDLE on the next edge and no further RAM writes are issued.
- States: IDLE -> RUN (on start) -> DONE.
  - DONE -> RUN on start.
  - start is ignored while in RUN.
- RAM outputs outside RUN: ram_en=0 and ram_rdwr=1 in IDLE and DONE.
- March sequence, run once per background, BG_A first then BG_B. "0" = background word, "1" = its complement.
  - E0: ascending, w0.
  - E1: ascending, r0 then w1.
  - E2: ascending, r1 then w0.
  - E3: descending, r0 then w1.
  - E4: descending, r1 then w0.
  - E5: descending, r0.
  - Ascending order is addresses 0..3; descending is 3..0.
- Write op: 1 cycle with ram_en=1, ram_rdwr=0, ram_ad and ram_data_in driven. The RAM captures at the closing edge.
- Read op: 1+READ_WAIT cycles with ram_en=1, ram_rdwr=1 and ram_ad held. ram_data_out is compared in the final cycle of the op.
- Op ordering: ops are back-to-back with no idle cycles; the first op is driven in the cycle after start is accepted.
- Cycle count: 20 writes and 20 reads per background, so busy lasts 2*(20+20*(1+READ_WAIT)) cycles (120 at default).
- Clean completion: after the last op, done=1, pass=1 and busy=0.
- Mismatch: on the first compare that differs, on the same edge:
  - capture fail_addr, fail_exp and fail_got;
  - go to DONE with pass=0;
  - drop ram_en, so no further ops are issued.
- Failure registers: cleared to 0 when a start is accepted; otherwise they hold through DONE.
- Cycle alignment: busy rises one cycle after the accepted start; done and busy change on the same edge.

Decomposition:
- Shared package ram_bist_pkg:
  - FSM state encoding (IDLE, RUN, DONE);
  - march element table constants (direction, op1/op2 type, op1/op2 data polarity);
  - element count constant (6) and background count constant (2).
- One sub-module, bist_addr_seq:
  - 2-bit up/down address counter with load-to-0 or load-to-3;
  - flags the last address so the top-level FSM can advance element and background indices.

Test Plan:
- Fault-free RAM model, default params, start pulse -> busy for exactly 120 cycles, then done=1, pass=1; fail_* fields = 0.
- Word 2 bit 1 stuck-at-0 -> fails in E2 of BG_A: done=1, pass=0, fail_addr=2, fail_exp=4'hF, fail_got=4'hD. No RAM write after the fail cycle.
- Address fault where writes/reads to address 3 alias to address 1 -> fails in E1 of BG_A: fail_addr=3, fail_exp=4'h0, fail_got=4'hF.
- start re-pulsed during RUN at cycle 10 -> ignored; total busy still 120 cycles and pass=1.
- rst asserted at RUN cycle 30 -> next edge: busy=0, done=0, ram_en=0; a later start runs a full 120-cycle pass.
- READ_WAIT=2, fault-free -> busy for 160 cycles; each read holds ram_ad for 3 cycles, compares only in the 3rd; pass=1.
